c1_conv_scheduler: RTL and testbench

- Sequencer for the LeNet-5 C1 convolution stage.
- Walks output rows, maps and columns. For each output pixel it issues one read to the window feature BRAM (feat_addr) and one read to the C1 kernel ROM (kern_addr), then pulses the convolver enable with a position tag, aligned to the 1-cycle synchronous read data.
- Requests a reload of the window BRAM from the loader between output rows.
- Sits between the host loader (start/load_down) and the convn C1 instance; replaces the free-running enable loop.

---
 rtl/c1_conv_scheduler.sv | 83 ++++++++
 tb/tb_c1_conv_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1_conv_scheduler.sv
// c1_conv_scheduler: walks C1 output rows/maps/cols, issuing feature and kernel reads
// with a one-cycle-delayed convolver enable and a window reload between rows.
module c1_conv_scheduler #(
  parameter int IMAGE = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int C1_MAPS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic load_down,
  input  logic hold,
  output logic row_req,
  output logic [$clog2(IMAGE)-1:0] req_row,
  output logic [$clog2(IMAGE)-1:0] feat_addr,
  output logic [((C1_MAPS > 1) ? $clog2(C1_MAPS) : 1)-1:0] kern_addr,
  output logic conv_en,
  output logic [$clog2(IMAGE)-1:0] out_row,
  output logic [$clog2(IMAGE)-1:0] out_col,
  output logic [((C1_MAPS > 1) ? $clog2(C1_MAPS) : 1)-1:0] out_map,
  output logic busy,
  output logic done
);
  localparam int OUT_SIZE = IMAGE - KERNEL_SIZE + 1;
  localparam int ADDR_WIDTH = $clog2(IMAGE);
  localparam int MAP_WIDTH = (C1_MAPS > 1) ? $clog2(C1_MAPS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(OUT_SIZE - 1);
  localparam logic [MAP_WIDTH-1:0] MAP_LAST = MAP_WIDTH'(C1_MAPS - 1);
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] row, col;
  logic [MAP_WIDTH-1:0] map;
  logic issue, col_last, map_last, row_last;
  always_comb begin
    issue = state == RUN && !hold;
    col_last = col == LAST;
    map_last = map == MAP_LAST;
    row_last = row == LAST;
    state_n = state;
    case (state)
      IDLE:      state_n = start ? WAIT_LOAD : IDLE;
      WAIT_LOAD: state_n = load_down ? RUN : WAIT_LOAD;
      RUN:       state_n = (issue && col_last && map_last) ? (row_last ? FLUSH : WAIT_LOAD) : RUN;
      FLUSH:     state_n = DONE;
      default:   state_n = IDLE;
    endcase
  end
  // the row counter wraps to 0 on the final issue so it never leaves its range
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      map <= '0;
      conv_en <= 1'b0;
      out_row <= '0;
      out_col <= '0;
      out_map <= '0;
    end else begin
      state <= state_n;
      conv_en <= issue;
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
        map <= '0;
      end
      if (issue) begin
        out_row <= row;
        out_col <= col;
        out_map <= map;
        col <= col_last ? '0 : col + ADDR_WIDTH'(1);
        if (col_last) map <= map_last ? '0 : map + MAP_WIDTH'(1);
        if (col_last && map_last) row <= row_last ? '0 : row + ADDR_WIDTH'(1);
      end
    end
  end
  assign row_req = state == WAIT_LOAD;
  assign req_row = row;
  assign feat_addr = col;
  assign kern_addr = map;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_c1_conv_scheduler.sv
// tb_c1_conv_scheduler: randomized-timing bench for a small (8px, 2 maps) and a default scheduler,
// checked against an index-arithmetic model of the row/map/col pulse order.
module tb_c1_conv_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, load_down = 1'b0, hold = 1'b0;
  logic row_req, conv_en, busy, done;
  logic [2:0] req_row, feat_addr, out_row, out_col;
  logic [0:0] kern_addr, out_map;

  logic d_start = 1'b0, d_load_down = 1'b0, d_hold = 1'b0;
  logic d_row_req, d_conv_en, d_busy, d_done;
  logic [4:0] d_req_row, d_feat_addr, d_out_row, d_out_col;
  logic [2:0] d_kern_addr, d_out_map;

  c1_conv_scheduler #(.IMAGE(8), .KERNEL_SIZE(5), .C1_MAPS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .load_down(load_down), .hold(hold),
    .row_req(row_req), .req_row(req_row), .feat_addr(feat_addr), .kern_addr(kern_addr),
    .conv_en(conv_en), .out_row(out_row), .out_col(out_col), .out_map(out_map),
    .busy(busy), .done(done));

  c1_conv_scheduler dut_d (
    .clk(clk), .rst(rst), .start(d_start), .load_down(d_load_down), .hold(d_hold),
    .row_req(d_row_req), .req_row(d_req_row), .feat_addr(d_feat_addr), .kern_addr(d_kern_addr),
    .conv_en(d_conv_en), .out_row(d_out_row), .out_col(d_out_col), .out_map(d_out_map),
    .busy(d_busy), .done(d_done));

  int passed = 0, total = 0;

  // small-instance monitor: pulse k of an image must be (k/8, (k/4)%2, k%4)
  int s_idx = 0, s_pulses = 0, s_tag_err = 0, s_align_err = 0, s_dones = 0, s_done_err = 0;
  int s_rr[$];
  logic s_prev_busy = 1'b0, s_prev_rr = 1'b0, s_prev_en = 1'b0;
  logic [2:0] s_prev_feat = '0, s_prev_row = '0;
  logic [0:0] s_prev_kern = '0;
  always @(negedge clk) begin
    if (busy && !s_prev_busy) begin
      s_idx = 0;
      s_rr.delete();
    end
    if (row_req && !s_prev_rr) s_rr.push_back(int'(req_row));
    if (conv_en) begin
      if (out_row !== 3'(s_idx / 8) || out_map !== 1'(s_idx / 4 % 2) || out_col !== 3'(s_idx % 4))
        s_tag_err++;
      if (out_col !== s_prev_feat || out_map !== s_prev_kern || out_row !== s_prev_row) s_align_err++;
      s_idx++;
      s_pulses++;
    end
    if (done) begin
      s_dones++;
      if (!s_prev_en || s_idx != 32) s_done_err++;
    end
    s_prev_busy = busy;
    s_prev_rr = row_req;
    s_prev_en = conv_en;
    s_prev_feat = feat_addr;
    s_prev_kern = kern_addr;
    s_prev_row = req_row;
  end

  // default-instance monitor: pulse k must be (k/168, (k/28)%6, k%28)
  int d_idx = 0, d_pulses = 0, d_tag_err = 0, d_align_err = 0, d_dones = 0, d_rr = 0;
  logic d_prev_busy = 1'b0, d_prev_rr = 1'b0;
  logic [4:0] d_prev_feat = '0, d_prev_row = '0;
  logic [2:0] d_prev_kern = '0;
  always @(negedge clk) begin
    if (d_busy && !d_prev_busy) d_idx = 0;
    if (d_row_req && !d_prev_rr) d_rr++;
    if (d_conv_en) begin
      if (d_out_row !== 5'(d_idx / 168) || d_out_map !== 3'(d_idx / 28 % 6) || d_out_col !== 5'(d_idx % 28))
        d_tag_err++;
      if (d_out_col !== d_prev_feat || d_out_map !== d_prev_kern || d_out_row !== d_prev_row) d_align_err++;
      d_idx++;
      d_pulses++;
    end
    if (d_done) d_dones++;
    d_prev_busy = d_busy;
    d_prev_rr = d_row_req;
    d_prev_feat = d_feat_addr;
    d_prev_kern = d_kern_addr;
    d_prev_row = d_req_row;
  end

  int hold_err, p_abort;
  bit hold_used, aborted, zero_ok, timed_out;

  // drives one image on the small instance; loader answers ld cycles after each row_req rise
  task automatic run_image(input int ld, input bit do_hold, input bit noise, input int abort_row,
                           input bit keep_start, input bit skip_start);
    int wc, hold_left;
    bit fin;
    wc = 0; hold_left = 0; fin = 0;
    hold_used = 0; hold_err = 0; aborted = 0; zero_ok = 0; timed_out = 0;
    if (!skip_start) begin
      start = 1'b1;
      load_down = noise;
    end
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = keep_start;
      load_down = 1'b0;
      if (done) fin = 1;
      else if (row_req) begin
        wc++;
        load_down = (wc == ld + 1);
      end else begin
        wc = 0;
        if (hold_left > 0) begin
          if (conv_en !== 1'b0 || feat_addr !== 3'd2) hold_err++;
          hold_left--;
          hold = (hold_left > 0);
        end else if (do_hold && !hold_used && busy && req_row == 3'd1 && kern_addr == 1'b0 && feat_addr == 3'd2) begin
          hold = 1'b1;
          hold_left = 5;
          hold_used = 1;
        end
        if (noise && busy && req_row == 3'd1) begin
          start = 1'b1;
          load_down = 1'b1;
        end
        if (abort_row >= 0 && busy && req_row == 3'(abort_row) && feat_addr == 3'd1) begin
          rst = 1'b0;
          @(posedge clk); #1;
          rst = 1'b1;
          p_abort = s_pulses;
          zero_ok = {row_req, req_row, feat_addr, kern_addr, conv_en, out_row, out_col, out_map, busy, done} === '0;
          aborted = 1;
          fin = 1;
        end
      end
    end
    timed_out = !fin;
    if (!keep_start) start = 1'b0;
    load_down = 1'b0;
    hold = 1'b0;
    if (!keep_start) repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if ({conv_en, done, row_req} !== 3'b0) $display("FAIL reset_ctrl got %b want 000", {conv_en, done, row_req}); else passed++;
    total++; if ({req_row, feat_addr, kern_addr} !== 7'b0) $display("FAIL reset_addr got %h want 0", {req_row, feat_addr, kern_addr}); else passed++;
    total++; if ({out_row, out_col, out_map} !== 7'b0) $display("FAIL reset_tags got %h want 0", {out_row, out_col, out_map}); else passed++;
    total++; if ({d_busy, d_conv_en, d_done, d_row_req} !== 4'b0) $display("FAIL reset_default got %b want 0000", {d_busy, d_conv_en, d_done, d_row_req}); else passed++;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b0) $display("FAIL idle_no_start got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_basic();
    int p0, t0, a0, d0, de0;
    p0 = s_pulses; t0 = s_tag_err; a0 = s_align_err; d0 = s_dones; de0 = s_done_err;
    run_image(3, 0, 0, -1, 0, 0);
    total++; if (timed_out) $display("FAIL basic_timeout got 1 want 0"); else passed++;
    total++; if (s_pulses - p0 != 32) $display("FAIL basic_pulses got %0d want 32", s_pulses - p0); else passed++;
    total++; if (s_tag_err != t0) $display("FAIL basic_tag_order got %0d errors want 0", s_tag_err - t0); else passed++;
    total++; if (s_align_err != a0) $display("FAIL basic_alignment got %0d errors want 0", s_align_err - a0); else passed++;
    total++; if (s_rr.size() != 4) $display("FAIL basic_row_req_count got %0d want 4", s_rr.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ((s_rr.size() > i ? s_rr[i] : -1) != i) $display("FAIL basic_req_row%0d got %0d want %0d", i, s_rr.size() > i ? s_rr[i] : -1, i);
      else passed++;
    end
    total++; if (s_dones - d0 != 1) $display("FAIL basic_done_count got %0d want 1", s_dones - d0); else passed++;
    total++; if (s_done_err != de0) $display("FAIL basic_done_timing got %0d errors want 0", s_done_err - de0); else passed++;
  endtask

  task automatic test_hold();
    int p0, t0, d0;
    p0 = s_pulses; t0 = s_tag_err; d0 = s_dones;
    run_image(2 + int'($urandom_range(0, 3)), 1, 0, -1, 0, 0);
    total++; if (!hold_used) $display("FAIL hold_reached got 0 want 1"); else passed++;
    total++; if (hold_err != 0) $display("FAIL hold_frozen got %0d errors want 0", hold_err); else passed++;
    total++; if (s_pulses - p0 != 32) $display("FAIL hold_pulses got %0d want 32", s_pulses - p0); else passed++;
    total++; if (s_tag_err != t0) $display("FAIL hold_tag_order got %0d errors want 0", s_tag_err - t0); else passed++;
    total++; if (s_dones - d0 != 1) $display("FAIL hold_done_count got %0d want 1", s_dones - d0); else passed++;
  endtask

  task automatic test_ignored();
    int p0, t0, d0;
    load_down = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    load_down = 1'b0;
    total++; if ({busy, row_req} !== 2'b00) $display("FAIL idle_load_down got %b want 00", {busy, row_req}); else passed++;
    p0 = s_pulses; t0 = s_tag_err; d0 = s_dones;
    run_image(3, 0, 1, -1, 0, 0);
    total++; if (s_rr.size() != 4) $display("FAIL ignored_row_req_count got %0d want 4", s_rr.size()); else passed++;
    total++; if (s_pulses - p0 != 32) $display("FAIL ignored_pulses got %0d want 32", s_pulses - p0); else passed++;
    total++; if (s_tag_err != t0) $display("FAIL ignored_tag_order got %0d errors want 0", s_tag_err - t0); else passed++;
    total++; if (s_dones - d0 != 1) $display("FAIL ignored_done_count got %0d want 1", s_dones - d0); else passed++;
  endtask

  task automatic test_reset_mid();
    int p0, t0, d0;
    d0 = s_dones;
    run_image(1, 0, 0, 2, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    total++; if (!aborted) $display("FAIL abort_reached got 0 want 1"); else passed++;
    total++; if (!zero_ok) $display("FAIL abort_outputs_zero got 0 want 1"); else passed++;
    total++; if (s_pulses != p_abort) $display("FAIL abort_no_pulse got %0d want 0", s_pulses - p_abort); else passed++;
    total++; if (s_dones != d0) $display("FAIL abort_no_done got %0d want 0", s_dones - d0); else passed++;
    p0 = s_pulses; t0 = s_tag_err; d0 = s_dones;
    run_image(int'($urandom_range(0, 4)), 0, 0, -1, 0, 0);
    total++; if (s_pulses - p0 != 32) $display("FAIL after_abort_pulses got %0d want 32", s_pulses - p0); else passed++;
    total++; if (s_tag_err != t0) $display("FAIL after_abort_tags got %0d errors want 0", s_tag_err - t0); else passed++;
    total++; if (s_dones - d0 != 1) $display("FAIL after_abort_done got %0d want 1", s_dones - d0); else passed++;
  endtask

  task automatic test_back_to_back();
    int p0, t0, d0;
    p0 = s_pulses; t0 = s_tag_err; d0 = s_dones;
    run_image(1, 0, 0, -1, 1, 0);
    total++; if (done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", done); else passed++;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL b2b_idle_gap got %b want 00", {busy, done}); else passed++;
    @(posedge clk); #1;
    total++; if ({busy, row_req} !== 2'b11) $display("FAIL b2b_restart got %b want 11", {busy, row_req}); else passed++;
    start = 1'b0;
    run_image(1, 0, 0, -1, 0, 1);
    total++; if (s_pulses - p0 != 64) $display("FAIL b2b_pulses got %0d want 64", s_pulses - p0); else passed++;
    total++; if (s_tag_err != t0) $display("FAIL b2b_tags got %0d errors want 0", s_tag_err - t0); else passed++;
    total++; if (s_dones - d0 != 2) $display("FAIL b2b_dones got %0d want 2", s_dones - d0); else passed++;
  endtask

  task automatic test_defaults();
    int p0, t0, a0, d0, r0;
    bit fin;
    p0 = d_pulses; t0 = d_tag_err; a0 = d_align_err; d0 = d_dones; r0 = d_rr;
    fin = 0;
    d_start = 1'b1;
    for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
      @(posedge clk); #1;
      d_start = 1'b0;
      d_load_down = d_row_req;
      if (d_done) fin = 1;
    end
    d_load_down = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (!fin) $display("FAIL default_timeout got 1 want 0"); else passed++;
    total++; if (d_pulses - p0 != 4704) $display("FAIL default_pulses got %0d want 4704", d_pulses - p0); else passed++;
    total++; if (d_rr - r0 != 28) $display("FAIL default_row_reqs got %0d want 28", d_rr - r0); else passed++;
    total++; if (d_dones - d0 != 1) $display("FAIL default_dones got %0d want 1", d_dones - d0); else passed++;
    total++; if (d_tag_err != t0) $display("FAIL default_tags got %0d errors want 0", d_tag_err - t0); else passed++;
    total++; if (d_align_err != a0) $display("FAIL default_alignment got %0d errors want 0", d_align_err - a0); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_defaults();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
